// File: rtl/range_tracker_pkg.sv
// Shared definitions for the range tracker: FSM state encoding and the
// default sample / counter widths used by the top-level parameters.
package range_tracker_pkg;

  localparam int DEF_DATA_W = 10;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : range_tracker_pkg

// File: rtl/range_tracker_cmp.sv
// Combinational min/max update: folds one unsigned sample into the current
// running minimum and maximum. Holds no state.
module range_tracker_cmp #(
  parameter int DATA_W = 10
) (
  input  logic [DATA_W-1:0] cur_min,
  input  logic [DATA_W-1:0] cur_max,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] next_min,
  output logic [DATA_W-1:0] next_max
);

  // Unsigned compare of the sample against the running extremes.
  always_comb begin
    next_min = cur_min;
    next_max = cur_max;
    if (sample < cur_min) begin
      next_min = sample;
    end else begin
      next_min = cur_min;
    end
    if (sample > cur_max) begin
      next_max = sample;
    end else begin
      next_max = cur_max;
    end
  end

endmodule : range_tracker_cmp

// File: rtl/range_tracker.sv
// Range tracker: opens a measurement window on start, folds valid samples
// into a running min/max/count, and publishes registered results one cycle
// after finish. Protocol misuse produces a one-cycle registered error pulse.
module range_tracker
  import range_tracker_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              finish,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] range_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              error
);

  localparam logic [DATA_W-1:0] DATA_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == CNT_MAX) begin
      return value;
    end else begin
      return value + CNT_W'(1);
    end
  endfunction

  state_e             state_r;
  state_e             state_next_s;
  logic [DATA_W-1:0]  run_min_r;
  logic [DATA_W-1:0]  run_max_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [DATA_W-1:0]  min_next_s;
  logic [DATA_W-1:0]  max_next_s;
  logic [CNT_W-1:0]   cnt_next_s;
  logic [DATA_W-1:0]  cmp_min_s;
  logic [DATA_W-1:0]  cmp_max_s;
  logic               load_result_s;
  logic               err_next_s;
  logic [DATA_W-1:0]  res_min_s;
  logic [DATA_W-1:0]  res_max_s;
  logic [CNT_W-1:0]   res_cnt_s;

  logic               busy_r;
  logic               result_valid_r;
  logic [DATA_W-1:0]  min_out_r;
  logic [DATA_W-1:0]  max_out_r;
  logic [DATA_W-1:0]  range_out_r;
  logic [CNT_W-1:0]   count_out_r;
  logic               error_r;

  range_tracker_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .cur_min  (run_min_r),
    .cur_max  (run_max_r),
    .sample   (sample_data),
    .next_min (cmp_min_s),
    .next_max (cmp_max_s)
  );

  // Next-state, running-accumulator and error decision for the window FSM.
  always_comb begin
    state_next_s  = state_r;
    min_next_s    = run_min_r;
    max_next_s    = run_max_r;
    cnt_next_s    = cnt_r;
    load_result_s = 1'b0;
    err_next_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && finish) begin
          err_next_s = 1'b1;
        end else if (start) begin
          state_next_s = ST_ACCUM;
          min_next_s   = DATA_ONES;
          max_next_s   = DATA_ZERO;
          cnt_next_s   = CNT_ZERO;
        end else if (finish) begin
          err_next_s = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        // A sample arriving with finish still belongs to this window.
        if (sample_valid) begin
          min_next_s = cmp_min_s;
          max_next_s = cmp_max_s;
          cnt_next_s = sat_inc(cnt_r);
        end else begin
          cnt_next_s = cnt_r;
        end
        if (start) begin
          // Covers both start-alone and start-with-finish: keep accumulating.
          err_next_s = 1'b1;
        end else if (finish) begin
          state_next_s  = ST_DONE;
          load_result_s = 1'b1;
          // An empty window is flagged alongside its result pulse.
          err_next_s    = (cnt_next_s == CNT_ZERO);
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        // DONE always returns to IDLE; a start here is silently dropped.
        state_next_s = ST_IDLE;
        if (finish) begin
          err_next_s = 1'b1;
        end else begin
          err_next_s = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Result values to publish when the window closes; an empty window reads as zero.
  always_comb begin
    res_min_s = DATA_ZERO;
    res_max_s = DATA_ZERO;
    res_cnt_s = CNT_ZERO;
    if (cnt_next_s != CNT_ZERO) begin
      res_min_s = min_next_s;
      res_max_s = max_next_s;
      res_cnt_s = cnt_next_s;
    end else begin
      res_min_s = DATA_ZERO;
      res_max_s = DATA_ZERO;
      res_cnt_s = CNT_ZERO;
    end
  end

  // State, accumulators and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      run_min_r      <= DATA_ZERO;
      run_max_r      <= DATA_ZERO;
      cnt_r          <= CNT_ZERO;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      min_out_r      <= DATA_ZERO;
      max_out_r      <= DATA_ZERO;
      range_out_r    <= DATA_ZERO;
      count_out_r    <= CNT_ZERO;
      error_r        <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      run_min_r      <= min_next_s;
      run_max_r      <= max_next_s;
      cnt_r          <= cnt_next_s;
      busy_r         <= (state_next_s == ST_ACCUM);
      result_valid_r <= load_result_s;
      error_r        <= err_next_s;
      if (load_result_s) begin
        min_out_r   <= res_min_s;
        max_out_r   <= res_max_s;
        range_out_r <= res_max_s - res_min_s;
        count_out_r <= res_cnt_s;
      end else begin
        min_out_r   <= min_out_r;
        max_out_r   <= max_out_r;
        range_out_r <= range_out_r;
        count_out_r <= count_out_r;
      end
    end
  end

  assign busy         = busy_r;
  assign result_valid = result_valid_r;
  assign min_out      = min_out_r;
  assign max_out      = max_out_r;
  assign range_out    = range_out_r;
  assign count_out    = count_out_r;
  assign error        = error_r;

endmodule : range_tracker

// File: tb/tb_range_tracker.sv
// Bench for range_tracker: directed scenarios followed by random traffic,
// all compared each cycle against a window-level reference model.
module tb_range_tracker;

  localparam int DW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          finish = 1'b0;

  logic          busy_a, rv_a, err_a;
  logic [DW-1:0] min_a, max_a, rng_a;
  logic [7:0]    cnt_a;
  logic          busy_b, rv_b, err_b;
  logic [DW-1:0] min_b, max_b, rng_b;
  logic [2:0]    cnt_b;

  int total = 0;
  int bad   = 0;

  // Reference model: window contents kept as a plain list of samples.
  int unsigned win_q[$];
  bit          m_open = 1'b0;
  bit          m_done = 1'b0;
  bit          e_busy, e_rv, e_err;
  int unsigned e_min, e_max, e_rng, e_cnt_a, e_cnt_b;

  range_tracker #(.DATA_W(DW), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .start(start), .sample_valid(sample_valid),
    .sample_data(sample_data), .finish(finish), .busy(busy_a),
    .result_valid(rv_a), .min_out(min_a), .max_out(max_a), .range_out(rng_a),
    .count_out(cnt_a), .error(err_a));

  range_tracker #(.DATA_W(DW), .CNT_W(3)) dut_b (
    .clock(clock), .reset(reset), .start(start), .sample_valid(sample_valid),
    .sample_data(sample_data), .finish(finish), .busy(busy_b),
    .result_valid(rv_b), .min_out(min_b), .max_out(max_b), .range_out(rng_b),
    .count_out(cnt_b), .error(err_b));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win_q.delete();
    m_open = 1'b0; m_done = 1'b0;
    e_busy = 1'b0; e_rv = 1'b0; e_err = 1'b0;
    e_min = 0; e_max = 0; e_rng = 0; e_cnt_a = 0; e_cnt_b = 0;
  endtask

  // Apply the protocol rules to one cycle of inputs.
  task automatic model_step(input bit st, input bit sv, input int unsigned d, input bit fin);
    int unsigned mn, mx;
    bit was_done;
    was_done = m_done;
    m_done = 1'b0;
    e_rv = 1'b0;
    e_err = 1'b0;
    if (m_open) begin
      if (sv) win_q.push_back(d);
      if (st) e_err = 1'b1;
      else if (fin) begin
        m_open = 1'b0;
        m_done = 1'b1;
        e_rv = 1'b1;
        if (win_q.size() == 0) begin
          e_err = 1'b1;
          e_min = 0; e_max = 0; e_rng = 0; e_cnt_a = 0; e_cnt_b = 0;
        end else begin
          mn = win_q[0]; mx = win_q[0];
          foreach (win_q[i]) begin
            if (win_q[i] < mn) mn = win_q[i];
            if (win_q[i] > mx) mx = win_q[i];
          end
          e_min = mn; e_max = mx; e_rng = mx - mn;
          e_cnt_a = (win_q.size() > 255) ? 255 : win_q.size();
          e_cnt_b = (win_q.size() > 7) ? 7 : win_q.size();
        end
      end
    end else if (fin) begin
      e_err = 1'b1;
    end else if (st && !was_done) begin
      m_open = 1'b1;
      win_q.delete();
    end
    e_busy = m_open;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"},  busy_a, e_busy);
    chk({tag, ".rv"},    rv_a,   e_rv);
    chk({tag, ".err"},   err_a,  e_err);
    chk({tag, ".min"},   min_a,  e_min);
    chk({tag, ".max"},   max_a,  e_max);
    chk({tag, ".range"}, rng_a,  e_rng);
    chk({tag, ".cnt"},   cnt_a,  e_cnt_a);
    chk({tag, ".cnt_b"}, cnt_b,  e_cnt_b);
  endtask

  // One clock of stimulus; called 1 time unit after a rising edge.
  task automatic step(input bit st, input bit sv, input int unsigned d, input bit fin,
                      input string tag);
    start = st; sample_valid = sv; sample_data = DW'(d); finish = fin;
    model_step(st, sv, d, fin);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic idle_step(input string tag);
    step(1'b0, 1'b0, 0, 1'b0, tag);
  endtask

  initial begin
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    check_all("reset");
    reset = 1'b0;
    idle_step("post_reset");

    // Basic window: min 37, max 512.
    step(1, 0, 0, 0, "w1_start");
    step(0, 1, 100, 0, "w1_s0");
    step(0, 1, 37, 0, "w1_s1");
    step(0, 1, 512, 0, "w1_s2");
    step(0, 1, 200, 0, "w1_s3");
    step(0, 0, 0, 1, "w1_fin");
    chk("w1_rv", rv_a, 1); chk("w1_min", min_a, 37); chk("w1_max", max_a, 512);
    chk("w1_range", rng_a, 475); chk("w1_cnt", cnt_a, 4); chk("w1_err", err_a, 0);
    idle_step("w1_hold");
    chk("w1_hold_min", min_a, 37);

    // Single sample together with finish.
    step(1, 0, 0, 0, "w2_start");
    step(0, 1, 5, 1, "w2_fin");
    chk("w2_min", min_a, 5); chk("w2_max", max_a, 5);
    chk("w2_range", rng_a, 0); chk("w2_cnt", cnt_a, 1);
    idle_step("w2_idle");

    // Empty window.
    step(1, 0, 0, 0, "w3_start");
    step(0, 0, 0, 1, "w3_fin");
    chk("w3_rv", rv_a, 1); chk("w3_err", err_a, 1); chk("w3_min", min_a, 0);
    chk("w3_cnt", cnt_a, 0);
    idle_step("w3_idle");
    chk("w3_err_clear", err_a, 0);

    // Protocol violations.
    step(1, 0, 0, 1, "v_both_idle");
    chk("v_both_err", err_a, 1); chk("v_both_busy", busy_a, 0);
    step(0, 0, 0, 1, "v_fin_idle");
    chk("v_fin_err", err_a, 1); chk("v_fin_busy", busy_a, 0);
    step(1, 0, 0, 0, "v_start");
    step(0, 1, 7, 0, "v_s0");
    step(0, 1, 9, 0, "v_s1");
    step(1, 0, 0, 0, "v_restart");
    chk("v_restart_err", err_a, 1); chk("v_restart_busy", busy_a, 1);
    step(0, 1, 3, 0, "v_s2");
    step(0, 0, 0, 1, "v_fin");
    chk("v_min", min_a, 3); chk("v_max", max_a, 9); chk("v_cnt", cnt_a, 3);
    step(1, 0, 0, 0, "v_start_done");
    chk("v_done_start_err", err_a, 0); chk("v_done_start_busy", busy_a, 0);

    // Counter saturation on the narrow instance.
    step(1, 0, 0, 0, "sat_start");
    for (int i = 0; i < 9; i++) step(0, 1, 10 + i, 0, "sat_s");
    step(0, 0, 0, 1, "sat_fin");
    chk("sat_cnt_b", cnt_b, 7); chk("sat_cnt_a", cnt_a, 9);
    idle_step("sat_idle");

    // Asynchronous reset in the middle of a window.
    step(1, 0, 0, 0, "r_start");
    step(0, 1, 40, 0, "r_s0");
    step(0, 1, 60, 0, "r_s1");
    reset = 1'b1;
    #1;
    model_reset();
    check_all("r_async");
    @(posedge clock); #1;
    check_all("r_held");
    reset = 1'b0;
    idle_step("r_idle");
    step(1, 0, 0, 0, "r2_start");
    step(0, 1, 20, 0, "r2_s0");
    step(0, 1, 30, 0, "r2_s1");
    step(0, 0, 0, 1, "r2_fin");
    chk("r2_min", min_a, 20); chk("r2_max", max_a, 30);
    chk("r2_range", rng_a, 10); chk("r2_cnt", cnt_a, 2);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1023), $urandom_range(0, 7) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_range_tracker
